fifo_wr_arbiter: RTL
====================

# fifo_wr_arbiter

Round-robin write-side arbiter that shares one `fifo_sync` instance between `NUM_REQ` valid/ready producers. It grants one producer at a time for a bounded burst and tags each word with the producer ID. It drives the FIFO `wr_en`/`wr_data` and never writes while `full` is high. It sits directly in front of the shared FIFO, so that downstream logic receives one interleaved, source-tagged stream.

## Interface
- `NUM_REQ`, 4: number of producers, 2..16.
- `DATA_WIDTH`, 16: payload width per producer.
- `ID_WIDTH`, 2: tag width. Must satisfy `2**ID_WIDTH >= NUM_REQ`.
- `BURST_LEN`, 4: maximum words per grant, 1..256.

- `clk` in 1: single clock. All state is on its rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `in_data` in `NUM_REQ*DATA_WIDTH`: producer payloads. Producer i occupies `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `in_valid` in `NUM_REQ`: producer word valid.
- `in_last` in `NUM_REQ`: marks the final word of a producer's packet. Qualified by a transfer.
- `in_ready` out `NUM_REQ`: one-hot or zero. Producer word accepted this cycle.
- `fifo_wr_data` out `ID_WIDTH+DATA_WIDTH`: `{owner_id, in_data[owner]}`.
- `fifo_wr_en` out 1: write strobe to the FIFO.
- `fifo_full` in 1: FIFO `full` flag.
- `grant_id` out `ID_WIDTH`: current owner. Zero when not busy.
- `busy` out 1: high while in GRANT.
- `stall_cnt` out 16: backpressure cycle counter (see Configuration).

## Operation
- State machine has two states, IDLE and GRANT. The registers are `state`, `owner`, `rr_ptr` and `burst_cnt` (8 bit).
- IDLE:
  - If any `in_valid` bit is set, select the first asserted index scanning upward from `rr_ptr`, wrapping modulo `NUM_REQ`.
  - On selection: `owner <= sel`, `burst_cnt <= 0`, go to GRANT.
  - No transfer occurs in IDLE.
- GRANT, transfer condition: `xfer = in_valid[owner] & ~fifo_full`.
  - On `xfer`: `fifo_wr_en = 1`, `in_ready[owner] = 1` (combinational), `burst_cnt++`.
  - No other `in_ready` bit is ever set.
- GRANT, release to IDLE with `rr_ptr <= (owner+1) mod NUM_REQ` on any of:
  - `xfer & in_last[owner]`;
  - `xfer & burst_cnt == BURST_LEN-1`;
  - `in_valid[owner] == 0` (producer idle). This release occurs regardless of `fifo_full`.
- `fifo_full` high with owner valid: hold GRANT. `fifo_wr_en`, `in_ready` and `burst_cnt` stay unchanged. A stall never causes a release.
- Transfers never occur in the release cycle after the last `xfer`. Each grant costs exactly one IDLE arbitration cycle.
- `fifo_wr_data` carries the owner tag and payload in GRANT. It is zero in IDLE.
- Arithmetic:
  - `burst_cnt` compares against `BURST_LEN-1` truncated to 8 bits.
  - `rr_ptr` wraps from `NUM_REQ-1` to 0 (explicit compare, not power-of-two wrap).
- Reset (asynchronous, any state including mid-burst):
  - `state = IDLE`, `owner = 0`, `rr_ptr = 0`, `burst_cnt = 0`, `stall_cnt = 0`.
  - Consequently `in_ready = 0`, `fifo_wr_en = 0`, `fifo_wr_data = 0`, `grant_id = 0`, `busy = 0`.
  - A partially sent burst is abandoned. The producer re-arbitrates after reset.

## Timing
- Request to first write: `in_valid` seen in IDLE at edge N. GRANT from N+1. First `fifo_wr_en` in cycle N+1 if `fifo_full` is low.
- Throughput: 1 word/cycle within a grant. A full `BURST_LEN` grant occupies `BURST_LEN+1` cycles.
- `fifo_wr_en`/`in_ready` depend combinationally on registered state, `in_valid`, `in_last` and `fifo_full`. `fifo_full` is register-derived in the FIFO, so there is no combinational loop.
- Overflow is impossible: `fifo_wr_en` is never high while `fifo_full` is high.

## Configuration
- `FIFO_WR_ARB_STALL_CNT_EN` defined:
  - `stall_cnt` increments every GRANT cycle with `in_valid[owner] & fifo_full`.
  - It saturates at 16'hFFFF and clears only on reset.
- Undefined: `stall_cnt` is constant 0 and no counter register is synthesized.
- All other behaviour is identical in both builds.

## Test plan
- Single burst with auto-rotation:
  - Stimulus: `BURST_LEN=4`. Only producer 1 is valid, with 6 words 0xA0..0xA5 and `in_last` on 0xA5.
  - Response: writes 0xA0..0xA3 tagged 1 in cycles 1–4. IDLE in cycle 5. 0xA4–0xA5 in cycles 6–7.
- Fairness under full load:
  - Stimulus: all 4 producers continuously valid.
  - Response: grant order 0,1,2,3,0. Each grant writes 4 words with the matching tag. 16 writes occur in 20 cycles.
- Early release on `in_last`:
  - Stimulus: producer 2 asserts `in_last` on its 2nd word while producer 3 is valid.
  - Response: 2 writes tagged 2, one IDLE cycle, then producer 3 is granted.
- Backpressure stall:
  - Stimulus: `fifo_full` held high for 3 cycles mid-burst.
  - Response: `fifo_wr_en` and `in_ready` stay low for 3 cycles. No word is lost or duplicated. The burst completes after the stall. `stall_cnt == 3` with the macro, 0 without.
- Idle release:
  - Stimulus: the owner drops `in_valid` after 1 word.
  - Response: return to IDLE and `rr_ptr` advances.
- Reset mid-burst:
  - Stimulus: `resetn` asserted during word 2 of a grant.
  - Response: all outputs 0 immediately (asynchronous). After release, arbitration restarts from `rr_ptr = 0`.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-side arbiter: grants one producer at a time for a bounded burst and
// tags each FIFO word with the owner ID. Define FIFO_WR_ARB_STALL_CNT_EN to build stall_cnt_o.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ID_WIDTH   = 2,
  parameter int unsigned BURST_LEN  = 4
) (
  input  logic                           clk_i,
  input  logic                           resetn_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  in_data_i,
  input  logic [NUM_REQ-1:0]             in_valid_i,
  input  logic [NUM_REQ-1:0]             in_last_i,
  output logic [NUM_REQ-1:0]             in_ready_o,
  output logic [ID_WIDTH+DATA_WIDTH-1:0] fifo_wr_data_o,
  output logic                           fifo_wr_en_o,
  input  logic                           fifo_full_i,
  output logic [ID_WIDTH-1:0]            grant_id_o,
  output logic                           busy_o,
  output logic [15:0]                    stall_cnt_o
);

  localparam logic [7:0]          BurstMax = 8'(BURST_LEN - 1);
  localparam logic [ID_WIDTH-1:0] LastId   = ID_WIDTH'(NUM_REQ - 1);

  typedef enum logic {StIdle, StGrant} state_e;

  state_e                state_q, state_d;
  logic [ID_WIDTH-1:0]   owner_q, owner_d;
  logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [7:0]            burst_cnt_q, burst_cnt_d;

  logic                  owner_valid, owner_last, xfer, sel_found;
  logic [DATA_WIDTH-1:0] owner_data;
  logic [ID_WIDTH-1:0]   sel_id, rr_next;

  always_comb begin
    owner_valid = 1'b0;
    owner_last  = 1'b0;
    owner_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (owner_q == ID_WIDTH'(i)) begin
        owner_valid = in_valid_i[i];
        owner_last  = in_last_i[i];
        owner_data  = in_data_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign xfer    = (state_q == StGrant) & owner_valid & ~fifo_full_i;
  assign rr_next = (owner_q == LastId) ? '0 : owner_q + 1'b1;

  // First valid producer scanning upward from rr_ptr_q, wrapping at NUM_REQ.
  always_comb begin
    int unsigned idx;
    sel_found = 1'b0;
    sel_id    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (!sel_found && idx == j && in_valid_i[j]) begin
          sel_found = 1'b1;
          sel_id    = ID_WIDTH'(j);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q     <= StIdle;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (sel_found) begin
          state_d     = StGrant;
          owner_d     = sel_id;
          burst_cnt_d = '0;
        end
      end
      StGrant: begin
        if (xfer) burst_cnt_d = burst_cnt_q + 8'd1;
        // A stalled but still-valid owner keeps the grant.
        if ((xfer && (owner_last || burst_cnt_q == BurstMax)) || !owner_valid) begin
          state_d  = StIdle;
          rr_ptr_d = rr_next;
        end
      end
    endcase
  end

  always_comb begin
    in_ready_o     = '0;
    fifo_wr_en_o   = xfer;
    busy_o         = (state_q == StGrant);
    grant_id_o     = busy_o ? owner_q : '0;
    fifo_wr_data_o = busy_o ? {owner_q, owner_data} : '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (xfer && owner_q == ID_WIDTH'(i)) in_ready_o[i] = 1'b1;
    end
  end

`ifdef FIFO_WR_ARB_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      stall_cnt_q <= '0;
    end else if (busy_o && owner_valid && fifo_full_i && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = 16'd0;
`endif

endmodule
